free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter FL_SIZE, default 96, meaning free-list depth (128 physical regs minus 32 architectural).
REQ-002 SHALL have parameter PR_W, default 7, meaning physical tag width.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port id_dispatch_num  input  2  number of tags consumed this cycle (0..2).
REQ-006 SHALL have port rob_retire_num  input  2  number of tags returned this cycle (0..2).
REQ-007 SHALL have ports rob_retire_told0, rob_retire_told1  input  7  freed old tags, slot 0 valid if num≥1, slot 1 valid if num=2.
REQ-008 SHALL have port recover  input  1  flush; restore to retired state.
REQ-009 SHALL have ports fl_pr0, fl_pr1  output  7  next two free tags, to rename map.
REQ-010 SHALL have port fl_avail_num  output  2  min(count,2).
REQ-011 SHALL have port fl_count  output  7  free entries, 0..FL_SIZE.

Function
REQ-012 SHALL hold tags in a circular buffer: head (allocate), tail (free), retired_head, count.
REQ-013 SHALL drive fl_pr0=buf[head], fl_pr1=buf[head+1 mod FL_SIZE] combinationally; values are don't-care when fl_avail_num does not cover them.
REQ-014 SHALL advance head by id_dispatch_num at the clock edge; a request above fl_avail_num is illegal and is clamped to fl_avail_num.
REQ-015 SHALL write told0 to buf[tail] and told1 to buf[tail+1] per rob_retire_num, advance tail and retired_head by rob_retire_num.
REQ-016 SHALL apply count_next = count − dispatch + retire on simultaneous dispatch and retire.
REQ-017 SHALL not bypass tags freed in cycle N to fl_pr0/1 before cycle N+1.
REQ-018 SHALL wrap all pointers modulo FL_SIZE (non-power-of-two): 95+1→0, 94+2→0, 95+2→1.
REQ-019 SHALL, on recover, ignore dispatch, still apply retire, set head←retired_head_next, count←FL_SIZE.
REQ-020 SHALL treat retire that would push count above FL_SIZE as illegal; count saturates at FL_SIZE.

Reset
REQ-021 SHALL on reset set buf[i]=32+i, head=tail=retired_head=0, count=FL_SIZE.
REQ-022 SHALL give reset priority over recover, dispatch and retire in the same cycle.
REQ-023 SHALL show after reset fl_pr0=32, fl_pr1=33, fl_avail_num=2, fl_count=96.

Configuration
REQ-024 SHALL, with FL_OVERFLOW_CHK_EN defined, add output fl_error (1 bit), sticky until reset, set on clamped dispatch (REQ-014) or saturated retire (REQ-020).
REQ-025 SHALL, without FL_OVERFLOW_CHK_EN, omit fl_error; clamp/saturate behaviour unchanged.

Structure
REQ-026 SHALL take FL_SIZE, PR_W, NUM_AR=32 and NUM_PR=128 from the shared rename package.
REQ-027 SHALL instantiate sub-module fl_ptr_add for modulo-FL_SIZE pointer add (ptr + 0..2), used three times.

Verification
REQ-028 Reset, then dispatch 2 -> next cycle fl_pr0=34, fl_pr1=35, fl_count=94.
REQ-029 Dispatch 2 and retire 2 (told 5, 9) in the same cycle from reset state -> fl_count=96, tags 5 and 9 appear only at positions 0,1 after 47 further 2-wide dispatches.
REQ-030 Dispatch until count=1 -> fl_avail_num=1; request 2 -> head advances 1, count=0, fl_error=1 when enabled.
REQ-031 Head at 95, dispatch 2 -> head=1; fl_pr0 at head 95 equals buf[95], fl_pr1 equals buf[0].
REQ-032 Dispatch 10, retire 4, recover with retire 2 in the same cycle -> head=retired_head=6, fl_count=96, dispatch that cycle ignored.

Source files
------------

// File: rtl/free_list_pkg.sv
// ---------------------------------------------------------------------------
// free_list_pkg
// Shared rename constants used by the free list and its pointer adder.
//   NUM_AR  : architectural registers (initial tag base for the free list)
//   NUM_PR  : physical registers
//   FL_SIZE : free-list depth (physical minus architectural)
//   PR_W    : physical tag width
// ---------------------------------------------------------------------------
package free_list_pkg;
    localparam int NUM_AR  = 32;
    localparam int NUM_PR  = 128;
    localparam int FL_SIZE = NUM_PR - NUM_AR;
    localparam int PR_W    = $clog2(NUM_PR);
endpackage

// File: rtl/free_list_ptr_add.sv
// ---------------------------------------------------------------------------
// fl_ptr_add
// Adds 0..2 to a circular-buffer pointer, wrapping modulo SIZE. SIZE need
// not be a power of two, so the wrap is an explicit compare-and-subtract.
// Ports:
//   ptr_i : current pointer (0..SIZE-1)
//   inc_i : increment (0..2)
//   sum_o : (ptr_i + inc_i) mod SIZE
// ---------------------------------------------------------------------------
module fl_ptr_add
    import free_list_pkg::*;
#(
    parameter int SIZE  = free_list_pkg::FL_SIZE,
    parameter int PTR_W = $clog2(SIZE)
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [1:0]       inc_i,
    output logic [PTR_W-1:0] sum_o
);
    localparam logic [PTR_W:0] SIZE_W = (PTR_W+1)'(SIZE);

    logic [PTR_W:0] raw;
    logic [PTR_W:0] wrapped;

    // One extra bit of headroom so ptr+2 never overflows before the compare.
    assign raw     = {1'b0, ptr_i} + {{(PTR_W-1){1'b0}}, inc_i};
    assign wrapped = raw - SIZE_W;
    assign sum_o   = (raw >= SIZE_W) ? wrapped[PTR_W-1:0] : raw[PTR_W-1:0];
endmodule

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
// Circular free list of physical register tags for a 2-wide rename stage.
// Tags are allocated at head, freed tags are written at tail, and
// retired_head tracks the head as seen by committed state so a flush can
// restore it.
// Ports:
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   id_dispatch_num          : tags consumed this cycle (0..2, clamped to avail)
//   rob_retire_num           : tags returned this cycle (0..2)
//   rob_retire_told0/1       : returned tags, slot 0 then slot 1
//   recover                  : flush; head restored from retired_head
//   fl_pr0, fl_pr1           : next two free tags (combinational from buffer)
//   fl_avail_num             : min(count, 2)
//   fl_count                 : number of free entries
//   fl_error                 : sticky illegal-request flag, only when the
//                              FL_OVERFLOW_CHK_EN macro is defined
// ---------------------------------------------------------------------------
module free_list #(
    parameter int FL_SIZE = free_list_pkg::FL_SIZE,
    parameter int PR_W    = free_list_pkg::PR_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [1:0]                   id_dispatch_num,
    input  logic [1:0]                   rob_retire_num,
    input  logic [PR_W-1:0]              rob_retire_told0,
    input  logic [PR_W-1:0]              rob_retire_told1,
    input  logic                         recover,
    output logic [PR_W-1:0]              fl_pr0,
    output logic [PR_W-1:0]              fl_pr1,
    output logic [1:0]                   fl_avail_num,
    output logic [$clog2(FL_SIZE+1)-1:0] fl_count
`ifdef FL_OVERFLOW_CHK_EN
    ,
    output logic                         fl_error
`endif
);
    import free_list_pkg::*;

    localparam int PTR_W = $clog2(FL_SIZE);
    localparam int CNT_W = $clog2(FL_SIZE+1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FL_SIZE-1);
    localparam logic [CNT_W:0]   FULL_WIDE = (CNT_W+1)'(FL_SIZE);

    logic [PR_W-1:0]  tag_q [FL_SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] rhead_q, rhead_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head_p1, tail_p1, head_adv;
    logic [1:0]       avail;
    logic [1:0]       disp_eff;
    logic [1:0]       ret_eff;
    logic [CNT_W:0]   count_sum;
    logic             count_over;

    // Single-step wrap, used only to address the second slot.
    function automatic logic [PTR_W-1:0] ptr_inc1(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head_p1 = ptr_inc1(head_q);
    assign tail_p1 = ptr_inc1(tail_q);

    assign avail = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];

    always_comb begin
        disp_eff = id_dispatch_num;
        if (id_dispatch_num > avail) begin
            disp_eff = avail;
        end
        if (recover) begin
            disp_eff = 2'd0;
        end
        // A retire count of 3 has no meaning on a 2-wide port; treat as 2.
        ret_eff = (rob_retire_num == 2'd3) ? 2'd2 : rob_retire_num;
    end

    fl_ptr_add #(.SIZE(FL_SIZE), .PTR_W(PTR_W)) u_head_add (
        .ptr_i (head_q),
        .inc_i (disp_eff),
        .sum_o (head_adv)
    );

    fl_ptr_add #(.SIZE(FL_SIZE), .PTR_W(PTR_W)) u_tail_add (
        .ptr_i (tail_q),
        .inc_i (ret_eff),
        .sum_o (tail_d)
    );

    fl_ptr_add #(.SIZE(FL_SIZE), .PTR_W(PTR_W)) u_rhead_add (
        .ptr_i (rhead_q),
        .inc_i (ret_eff),
        .sum_o (rhead_d)
    );

    // disp_eff never exceeds count, so the subtraction cannot underflow.
    assign count_sum  = {1'b0, count_q} - (CNT_W+1)'(disp_eff) + (CNT_W+1)'(ret_eff);
    assign count_over = (count_sum > FULL_WIDE);

    always_comb begin
        head_d  = head_adv;
        count_d = count_over ? CNT_W'(FL_SIZE) : count_sum[CNT_W-1:0];
        if (recover) begin
            head_d  = rhead_d;
            count_d = CNT_W'(FL_SIZE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            rhead_q <= '0;
            count_q <= CNT_W'(FL_SIZE);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            count_q <= count_d;
        end
    end

    // Each entry resets to its own tag and is written by whichever retire
    // slot points at it this cycle.
    generate
        for (genvar gi = 0; gi < FL_SIZE; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    tag_q[gi] <= PR_W'(NUM_AR + gi);
                end else if ((ret_eff != 2'd0) && (tail_q == PTR_W'(gi))) begin
                    tag_q[gi] <= rob_retire_told0;
                end else if ((ret_eff == 2'd2) && (tail_p1 == PTR_W'(gi))) begin
                    tag_q[gi] <= rob_retire_told1;
                end
            end
        end
    endgenerate

    // Reads come from registered state only, so a tag freed this cycle is
    // visible at the earliest on the next cycle.
    assign fl_pr0       = tag_q[head_q];
    assign fl_pr1       = tag_q[head_p1];
    assign fl_avail_num = avail;
    assign fl_count     = count_q;

`ifdef FL_OVERFLOW_CHK_EN
    logic error_q;
    logic error_hit;

    // A flush discards dispatch, so only non-recover cycles can be illegal.
    assign error_hit = !recover && ((id_dispatch_num > avail) || count_over);

    always_ff @(posedge clock) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (error_hit) begin
            error_q <= 1'b1;
        end
    end

    assign fl_error = error_q;
`endif
endmodule
